uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Arbitrates between two frame requesters (ALU result path and register-file read path) for the single UART transmitter and sequences each accepted request into one or two byte frames. It owns the transmitter's `data_valid`/`p_data` inputs and tracks the transmitter's `busy` output to know when each frame has finished. It sits between the system control logic and the UART TX top.

## Interface
- `DATA_WIDTH`, default 8: width of one UART frame payload.
- `TIMEOUT_CYC`, default 15: cycles allowed in WAIT_BUSY before abort. Used only with `TX_SCHED_TIMEOUT_EN`.
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 (ALU) has a word.
- `req0_data` input 2*DATA_WIDTH: requester 0 word; low byte is sent first.
- `req0_two` input 1: 1 sends both bytes; 0 sends the low byte only.
- `req0_ready` output 1: requester 0 accepted this cycle.
- `req1_valid`, `req1_data`, `req1_two`, `req1_ready`: same as the requester 0 ports, for requester 1 (register file).
- `tx_busy` input 1: transmitter busy flag.
- `tx_data_valid` output 1: one-cycle frame-start pulse to the transmitter.
- `tx_p_data` output DATA_WIDTH: byte presented to the transmitter.
- `sched_busy` output 1: high whenever the state is not IDLE.
- `owner` output 1: index of the requester being served; holds the last value while in IDLE.
- `err_timeout` output 1: one-cycle abort pulse.

## Operation
- States:
  - IDLE
  - SEND: drives the `tx_data_valid` pulse.
  - WAIT_BUSY: waits for `tx_busy`=1.
  - WAIT_DONE: waits for `tx_busy`=0.
- Arbitration happens in IDLE only and is combinational on the `valid` inputs and `last_grant`:
  - One requester valid: that requester gets `ready`=1.
  - Both valid: the requester that is not `last_grant` wins.
  - At most one `ready` is high per cycle. All `ready` outputs are 0 outside IDLE.
- Acceptance (`valid`&`ready` at an edge):
  - Latches the word into `hold_data`.
  - Sets `pending` = `two` ? 2 : 1 and `byte_idx`=0.
  - Sets `owner` and `last_grant` to the winner.
  - Moves to SEND.
- SEND, for one cycle:
  - `tx_data_valid`=1.
  - `tx_p_data` = `hold_data` low byte when `byte_idx`=0, high byte when `byte_idx`=1.
  - Then moves to WAIT_BUSY.
- WAIT_BUSY: stays until `tx_busy`=1, then moves to WAIT_DONE.
- WAIT_DONE: stays until `tx_busy`=0. On exit, `pending` decrements:
  - If `pending` is still nonzero: `byte_idx`=1 and go to SEND.
  - Otherwise go to IDLE.
- `tx_p_data` holds its value from SEND until the next SEND, so it stays stable through the whole frame.
- A requester must hold `valid` and `data` until it sees `ready`. Changes to `data` after acceptance are ignored.

## Timing
- Reset values:
  - State IDLE.
  - `last_grant`=1, so requester 0 wins the first tie.
  - `owner`=0, `tx_data_valid`=0, `tx_p_data`=0, `sched_busy`=0, `err_timeout`=0, `pending`=0, `byte_idx`=0.
  - Timeout counter 0.
- Reset mid-frame: the state returns to IDLE at the next edge and any remaining byte is dropped. The transmitter finishing a frame afterwards has no effect on this block.
- Latency: acceptance at edge T gives `tx_data_valid`=1 during cycle T+1.
- Second byte: `tx_data_valid` rises in the cycle after WAIT_DONE sees `tx_busy`=0.
- Minimum gap from IDLE to the next acceptance is 0 cycles. `ready` can assert in the first IDLE cycle.
- `tx_busy`=1 already present on entry to WAIT_BUSY: WAIT_BUSY lasts exactly 1 cycle.
- A `tx_busy` pulse shorter than 1 cycle cannot occur, because `tx_busy` is registered in the transmitter.
- Two-byte word, back to back with a waiting request: the other requester is served next, even if the current requester is still valid.

## Configuration
- `TX_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT_BUSY and clears on entry to SEND.
  - When it reaches `TIMEOUT_CYC` without `tx_busy`=1, the block pulses `err_timeout` for 1 cycle, clears `pending`, and goes to IDLE.
- `TX_SCHED_TIMEOUT_EN` undefined:
  - WAIT_BUSY waits indefinitely.
  - `err_timeout` is tied to 0 and no counter is instantiated.

## Test plan
- Single byte: `req0_valid`=1, `req0_data`=16'h12A5, `req0_two`=0 → `req0_ready` for 1 cycle, `tx_data_valid` pulse with `tx_p_data`=8'hA5, one frame, `sched_busy` falls when `tx_busy` falls.
- Two bytes: `req1` with data 16'hBEEF, `two`=1 → frames 8'hEF then 8'hBE, exactly two `tx_data_valid` pulses, `owner`=1 throughout.
- Tie after reset: `req0` and `req1` both valid with `two`=0 → `req0` served first, then `req1`. Repeating the tie gives alternating grants 0,1,0,1.
- Back-to-back stream: `req0` continuously valid, `req1` asserted during `req0`'s frame → `req1` wins the next IDLE cycle; no `tx_data_valid` pulse while `tx_busy`=1.
- Reset mid-frame: assert `rst` while in WAIT_DONE of byte 0 of a two-byte word → all outputs return to reset values next cycle and no second byte is sent.
- Timeout (macro defined, `TIMEOUT_CYC`=15): hold `tx_busy`=0 after SEND → `err_timeout` pulses 15 cycles after WAIT_BUSY entry, then IDLE, and a new request is accepted.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - two-requester arbiter and byte-frame sequencer for the UART transmitter
// Optional feature macro: TX_SCHED_TIMEOUT_EN (abort WAIT_BUSY after TIMEOUT_CYC cycles without tx_busy)
module uart_tx_scheduler #(
   parameter int DATA_WIDTH  = 8,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req0_valid,
   input  logic [2*DATA_WIDTH-1:0] req0_data,
   input  logic                    req0_two,
   output logic                    req0_ready,
   input  logic                    req1_valid,
   input  logic [2*DATA_WIDTH-1:0] req1_data,
   input  logic                    req1_two,
   output logic                    req1_ready,
   input  logic                    tx_busy,
   output logic                    tx_data_valid,
   output logic [DATA_WIDTH-1:0]   tx_p_data,
   output logic                    sched_busy,
   output logic                    owner,
   output logic                    err_timeout
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [2*DATA_WIDTH-1:0] hold_data;
   logic [1:0]              pending;
   logic                    byte_idx;
   logic                    last_grant;
   logic                    grant0;
   logic                    grant1;
   logic                    accept;
   logic                    timeout_hit;
   logic [DATA_WIDTH-1:0]   cur_byte;
   logic [DATA_WIDTH-1:0]   p_data_q;

   // Arbitration in IDLE: a lone valid wins, a tie goes to the requester not granted last
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE) begin
         grant0 = req0_valid && (!req1_valid || last_grant);
         grant1 = req1_valid && (!req0_valid || !last_grant);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 || grant1;

`ifdef TX_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] to_cnt;

   // Counts WAIT_BUSY cycles without tx_busy; any other state (SEND included) holds it at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == WAIT_BUSY) begin
         if (!tx_busy) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end else begin
         to_cnt <= '0;
      end
   end

   assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (to_cnt == CW'(TIMEOUT_CYC));
`else
   // Without the abort path WAIT_BUSY waits forever; the expression is a constant zero
   assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

   assign err_timeout = timeout_hit;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = SEND;
            end
         end
         SEND: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (timeout_hit) begin
               state_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_next = (pending > 2'd1) ? SEND : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Word capture on acceptance and byte stepping when a frame completes
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data  <= '0;
         pending    <= 2'd0;
         byte_idx   <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  hold_data  <= grant1 ? req1_data : req0_data;
                  pending    <= (grant1 ? req1_two : req0_two) ? 2'd2 : 2'd1;
                  byte_idx   <= 1'b0;
                  owner      <= grant1;
                  last_grant <= grant1;
               end
            end
            WAIT_BUSY: begin
               if (timeout_hit) begin
                  pending <= 2'd0;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  pending <= pending - 2'd1;
                  if (pending > 2'd1) begin
                     byte_idx <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign cur_byte = byte_idx ? hold_data[2*DATA_WIDTH-1:DATA_WIDTH] : hold_data[DATA_WIDTH-1:0];

   // Keep the last sent byte so tx_p_data stays stable while the transmitter shifts it out
   always_ff @(posedge clk) begin
      if (rst) begin
         p_data_q <= '0;
      end else if (state == SEND) begin
         p_data_q <= cur_byte;
      end
   end

   assign tx_p_data     = (state == SEND) ? cur_byte : p_data_q;
   assign tx_data_valid = (state == SEND);
   assign sched_busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

   localparam int TO = 15;
`ifdef TX_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid;
   logic [15:0] req0_data;
   logic        req0_two;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_data;
   logic        req1_two;
   logic        req1_ready;
   logic        tx_busy;
   logic        tx_data_valid;
   logic [7:0]  tx_p_data;
   logic        sched_busy;
   logic        owner;
   logic        err_timeout;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.DATA_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_two(req0_two), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_two(req1_two), .req1_ready(req1_ready),
      .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data),
      .sched_busy(sched_busy), .owner(owner), .err_timeout(err_timeout)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // transmitter stand-in: busy window per frame
   int busy_start = -1;
   int busy_end   = -1;
   bit tx_silent  = 1'b0;
   bit fixed_tx   = 1'b1;

   // stimulus control
   bit rand_mode = 1'b0;
   bit hold0     = 1'b0;
   bit acc0, acc1;

   // transaction-level model: bytes still owed for the current word and where the frame stands
   bit         m_active, m_send_now, m_seen_busy, m_owner, m_last;
   logic [7:0] m_pdata;
   logic [7:0] m_bytes[$];
   int         m_wait;
   bit         m_r0, m_r1;

   logic [8:0] frames[$];
   int         grants[$];
   int         pulse_cyc = -1;
   int         err_cyc   = -1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_send_now = 0; m_seen_busy = 0; m_owner = 0; m_last = 1;
      m_pdata = 8'h00; m_bytes.delete(); m_wait = 0;
   endtask

   task automatic step();
      logic [15:0] d;
      bit          two;
      bit          exp_err;
      @(negedge clk);
      m_r0 = 0;
      m_r1 = 0;
      if (!m_active) begin
         if (req0_valid && (!req1_valid || m_last)) m_r0 = 1;
         else if (req1_valid) m_r1 = 1;
      end
      exp_err = TO_EN && m_active && !m_send_now && !m_seen_busy && !tx_busy && (m_wait == TO);
      chk("req0_ready", req0_ready, m_r0);
      chk("req1_ready", req1_ready, m_r1);
      chk("sched_busy", sched_busy, m_active);
      chk("tx_data_valid", tx_data_valid, m_active && m_send_now);
      chk("tx_p_data", tx_p_data, m_pdata);
      chk("owner", owner, m_owner);
      chk("err_timeout", err_timeout, exp_err);
      if (err_timeout) err_cyc = cyc;
      if (tx_data_valid) begin
         chk("no_pulse_while_busy", tx_busy, 0);
         frames.push_back({owner, tx_p_data});
         pulse_cyc  = cyc;
         busy_start = cyc + 1 + (fixed_tx ? 1 : int'($urandom_range(0, 2)));
         busy_end   = busy_start + (fixed_tx ? 3 : int'($urandom_range(1, 5)));
         if (tx_silent || (TO_EN && rand_mode && $urandom_range(0, 7) == 0)) busy_start = -1;
      end
      acc0 = m_r0 && !rst;
      acc1 = m_r1 && !rst;
      // advance the model across the coming edge
      if (rst) begin
         model_reset();
      end else if (!m_active) begin
         if (m_r0 || m_r1) begin
            d   = m_r1 ? req1_data : req0_data;
            two = m_r1 ? req1_two : req0_two;
            m_bytes.delete();
            m_bytes.push_back(d[7:0]);
            if (two) m_bytes.push_back(d[15:8]);
            m_active = 1; m_send_now = 1; m_owner = m_r1; m_last = m_r1; m_pdata = d[7:0];
            grants.push_back(int'(m_r1));
         end
      end else if (m_send_now) begin
         m_send_now = 0; m_seen_busy = 0; m_wait = 0;
      end else if (!m_seen_busy) begin
         if (tx_busy) m_seen_busy = 1;
         else if (exp_err) begin m_active = 0; m_bytes.delete(); end
         else m_wait++;
      end else if (!tx_busy) begin
         void'(m_bytes.pop_front());
         if (m_bytes.size() == 0) m_active = 0;
         else begin m_send_now = 1; m_pdata = m_bytes[0]; end
      end
      @(posedge clk);
      cyc++;
      #1;
      tx_busy = !tx_silent && busy_start >= 0 && cyc >= busy_start && cyc < busy_end;
      if (rand_mode) begin
         if (acc0 || (!req0_valid && $urandom_range(0, 2) == 0)) begin
            req0_valid = acc0 ? ($urandom_range(0, 3) != 0) : 1'b1;
            req0_data  = 16'($urandom);
            req0_two   = 1'($urandom);
         end
         if (acc1 || (!req1_valid && $urandom_range(0, 2) == 0)) begin
            req1_valid = acc1 ? ($urandom_range(0, 3) != 0) : 1'b1;
            req1_data  = 16'($urandom);
            req1_two   = 1'($urandom);
         end
      end else begin
         if (acc0 && !hold0) begin req0_valid = 0; req0_data = 16'($urandom); end
         if (acc1) begin req1_valid = 0; req1_data = 16'($urandom); end
      end
   endtask

   task automatic wait_idle(int max);
      int n = 0;
      step();
      while ((sched_busy || req0_valid || req1_valid) && n < max) begin
         step();
         n++;
      end
      chk("idle_reached", sched_busy, 0);
   endtask

   task automatic do_reset();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1; req0_valid = 0; req0_data = 0; req0_two = 0;
      req1_valid = 0; req1_data = 0; req1_two = 0; tx_busy = 0;
      model_reset();
      do_reset();
      step();
      chk("rst_sched_busy", sched_busy, 0);
      chk("rst_owner", owner, 0);
      chk("rst_tx_p_data", tx_p_data, 8'h00);
      chk("rst_tx_data_valid", tx_data_valid, 0);

      // single byte from requester 0
      frames.delete();
      req0_valid = 1; req0_data = 16'h12A5; req0_two = 0;
      wait_idle(60);
      chk("single_count", frames.size(), 1);
      chk("single_frame", frames[0], 9'h0A5);

      // two bytes from requester 1, low byte first
      frames.delete();
      req1_valid = 1; req1_data = 16'hBEEF; req1_two = 1;
      wait_idle(60);
      chk("two_count", frames.size(), 2);
      chk("two_frame0", frames[0], 9'h1EF);
      chk("two_frame1", frames[1], 9'h1BE);

      // repeated ties after reset alternate 0,1,0,1
      do_reset();
      frames.delete();
      grants.delete();
      for (int i = 0; i < 2; i++) begin
         req0_valid = 1; req0_data = 16'h7711; req0_two = 0;
         req1_valid = 1; req1_data = 16'h6622; req1_two = 0;
         wait_idle(80);
      end
      chk("tie_count", frames.size(), 4);
      chk("tie_f0", frames[0], 9'h011);
      chk("tie_f1", frames[1], 9'h122);
      chk("tie_f2", frames[2], 9'h011);
      chk("tie_f3", frames[3], 9'h122);
      chk("tie_model_g1", grants[1], 1);
      chk("tie_model_g2", grants[2], 0);

      // back-to-back stream: req1 arriving mid-word is served before req0 again
      frames.delete();
      hold0 = 1;
      req0_valid = 1; req0_data = 16'h3344; req0_two = 1;
      n = 0;
      step();
      while (!acc0 && n < 20) begin step(); n++; end
      chk("b2b_accept0", acc0, 1);
      req1_valid = 1; req1_data = 16'h9955; req1_two = 0;
      n = 0;
      while (frames.size() < 3 && n < 80) begin step(); n++; end
      hold0 = 0;
      req0_valid = 0;
      wait_idle(80);
      chk("b2b_f0", frames[0], 9'h044);
      chk("b2b_f1", frames[1], 9'h033);
      chk("b2b_f2", frames[2], 9'h155);

      // reset in WAIT_DONE of byte 0 drops byte 1
      frames.delete();
      req1_valid = 1; req1_data = 16'hA1B2; req1_two = 1;
      n = 0;
      step();
      while (!(m_active && m_seen_busy && !m_send_now && m_bytes.size() == 2) && n < 40) begin
         step();
         n++;
      end
      chk("mid_reached_wait_done", sched_busy, 1);
      rst = 1;
      step();
      rst = 0;
      step();
      chk("mid_sched_busy", sched_busy, 0);
      chk("mid_owner", owner, 0);
      chk("mid_tx_p_data", tx_p_data, 8'h00);
      for (int i = 0; i < 20; i++) step();
      chk("mid_one_frame", frames.size(), 1);
      chk("mid_frame0", frames[0], 9'h1B2);

      if (TO_EN) begin
         // transmitter never answers: abort 15 cycles after WAIT_BUSY entry
         tx_silent = 1;
         err_cyc = -1;
         req0_valid = 1; req0_data = 16'h00C3; req0_two = 1;
         n = 0;
         step();
         while (err_cyc < 0 && n < 60) begin step(); n++; end
         chk("to_latency", err_cyc - pulse_cyc, 16);
         step();
         chk("to_idle", sched_busy, 0);
         tx_silent = 0;
         frames.delete();
         req1_valid = 1; req1_data = 16'h005A; req1_two = 0;
         wait_idle(60);
         chk("to_recover", frames.size(), 1);
      end

      // randomized traffic against the model
      fixed_tx = 0;
      rand_mode = 1;
      for (int i = 0; i < 4000; i++) step();
      rand_mode = 0;
      req0_valid = 0;
      req1_valid = 0;
      wait_idle(200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
